regfile_sb: RTL and testbench

Parametrised successor to the decode-stage register file: an N-read/1-write integer register file with a hardwired zero register and asynchronous clear. It adds a per-register pending-write scoreboard and a hazard stall output. It sits in the decode stage. Decode presents source addresses and the destination of the instruction being issued. Writeback drives the write port and retires pending entries.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_scoreboard.sv | 86 ++++++++
 rtl/regfile_sb.sv | 83 ++++++++
 tb/tb_regfile_sb.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the decode-stage register file.
// Holds the zero-register index, default sizes and the flat-port slice offset.
package regfile_pkg;

  localparam int ZERO_REG       = 0;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_REGS   = 32;

  // Bit offset of port k inside a flattened bus of w-bit fields.
  function automatic int slice_off(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one pending bit per register, a registered
// count of set bits, and the rd_busy / stall hazard outputs.
// Ports: clk, rst (async, active-high), write_enable/wa (writeback clear),
//   ra (flattened sources), issue_valid/issue_has_rd/issue_rd (set),
//   rd_busy, stall, pending_cnt.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS),
  parameter int NUM_READ   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           write_enable,
  input  logic [ADDR_WIDTH-1:0]          wa,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] ra,
  input  logic                           issue_valid,
  input  logic                           issue_has_rd,
  input  logic [ADDR_WIDTH-1:0]          issue_rd,
  output logic [NUM_READ-1:0]            rd_busy,
  output logic                           stall,
  output logic [ADDR_WIDTH:0]            pending_cnt
);

  localparam int CW = ADDR_WIDTH + 1;

  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] pend_d;
  logic [CW-1:0]       cnt_q;
  logic                clr;
  logic                set;
  logic                waw;
  logic                inc;
  logic                dec;

  assign clr = write_enable
            && (int'(wa) != ZERO_REG);

  // Register 0 is never pending, so its lookup is always 0.
  for (genvar k = 0; k < NUM_READ; k++) begin : g_busy
    logic [ADDR_WIDTH-1:0] a;
    assign a = ra[slice_off(k, ADDR_WIDTH)
                  +: ADDR_WIDTH];
    assign rd_busy[k] = pend_q[a]
                     && !(clr && wa == a);
  end

  assign waw = issue_has_rd
            && (int'(issue_rd) != ZERO_REG)
            && pend_q[issue_rd]
            && !(clr && wa == issue_rd);

  assign stall = issue_valid
              && ((|rd_busy) || waw);

  assign set = issue_valid && !stall
            && issue_has_rd
            && (int'(issue_rd) != ZERO_REG);

  // Count real bit transitions only: a set that lands on a bit being
  // cleared in the same edge is a net change of zero.
  assign inc = set && !pend_q[issue_rd];
  assign dec = clr && pend_q[wa]
            && !(set && issue_rd == wa);

  // Set is applied last so a new producer wins over the retiring one.
  always_comb begin
    pend_d = pend_q;
    if (clr) pend_d[wa] = 1'b0;
    if (set) pend_d[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_q + CW'(inc) - CW'(dec);
    end
  end

  assign pending_cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// N-read/1-write register file with hardwired x0, async clear and a
// pending-write scoreboard. Optional macro: REGFILE_BYPASS_EN (forwarding).
// Ports: clk, rst, write_enable/wa/wd, ra/rd (flattened), rd_busy,
//   issue_valid/issue_has_rd/issue_rd, stall, pending_cnt.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS),
  parameter int NUM_READ   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           write_enable,
  input  logic [ADDR_WIDTH-1:0]          wa,
  input  logic [DATA_WIDTH-1:0]          wd,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] ra,
  output logic [NUM_READ*DATA_WIDTH-1:0] rd,
  output logic [NUM_READ-1:0]            rd_busy,
  input  logic                           issue_valid,
  input  logic                           issue_has_rd,
  input  logic [ADDR_WIDTH-1:0]          issue_rd,
  output logic                           stall,
  output logic [ADDR_WIDTH:0]            pending_cnt
);

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];
  logic                  wr_ok;

  assign wr_ok = write_enable
              && (int'(wa) != ZERO_REG);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wa] <= wd;
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] v;

    assign a = ra[slice_off(k, ADDR_WIDTH)
                  +: ADDR_WIDTH];

    always_comb begin
      v = mem[a];
`ifdef REGFILE_BYPASS_EN
      // A write held under reset is discarded, so never forward it.
      if (wr_ok && !rst && wa == a)
        v = wd;
`endif
      if (int'(a) == ZERO_REG)
        v = '0;
    end

    assign rd[slice_off(k, DATA_WIDTH)
              +: DATA_WIDTH] = v;
  end

  regfile_scoreboard #(
    .NUM_REGS   (NUM_REGS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_READ   (NUM_READ)
  ) u_sb (
    .clk          (clk),
    .rst          (rst),
    .write_enable (write_enable),
    .wa           (wa),
    .ra           (ra),
    .issue_valid  (issue_valid),
    .issue_has_rd (issue_has_rd),
    .issue_rd     (issue_rd),
    .rd_busy      (rd_busy),
    .stall        (stall),
    .pending_cnt  (pending_cnt)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed table, hand sequences
// and randomized traffic against a behavioural model.
module tb_regfile_sb;

  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int AW  = 5;
  localparam int NRD = 2;
`ifdef REGFILE_BYPASS_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           write_enable;
  logic [AW-1:0]  wa;
  logic [DW-1:0]  wd;
  logic [NRD*AW-1:0] ra;
  logic [NRD*DW-1:0] rd;
  logic [NRD-1:0] rd_busy;
  logic           issue_valid;
  logic           issue_has_rd;
  logic [AW-1:0]  issue_rd;
  logic           stall;
  logic [AW:0]    pending_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_sb #(
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR),
    .ADDR_WIDTH (AW),
    .NUM_READ   (NRD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .write_enable (write_enable),
    .wa           (wa),
    .wd           (wd),
    .ra           (ra),
    .rd           (rd),
    .rd_busy      (rd_busy),
    .issue_valid  (issue_valid),
    .issue_has_rd (issue_has_rd),
    .issue_rd     (issue_rd),
    .stall        (stall),
    .pending_cnt  (pending_cnt)
  );

  // Behavioural model: register contents and a set of pending registers.
  logic [DW-1:0] m_mem [NR];
  bit            m_pend [NR];
  logic [DW-1:0] e_rd [NRD];
  bit            e_busy [NRD];
  bit            e_stall;
  int            e_cnt;

  typedef struct {
    bit          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    bit          iv;
    bit          hrd;
    logic [AW-1:0] ird;
    logic [DW-1:0] rd0;
    logic [DW-1:0] rd1;
    logic [1:0]  busy;
    bit          stall;
    int          cnt;
  } vec_t;

  vec_t tab [12];

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic idle();
    write_enable = 1'b0;
    wa           = '0;
    wd           = '0;
    ra           = '0;
    issue_valid  = 1'b0;
    issue_has_rd = 1'b0;
    issue_rd     = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  task automatic model_eval();
    logic [AW-1:0] a;
    bit waw;
    int n;
    for (int k = 0; k < NRD; k++) begin
      a = ra[k*AW +: AW];
      e_busy[k] = (a != 0) && m_pend[a]
               && !(write_enable && wa == a);
      if (a == 0)
        e_rd[k] = '0;
      else if (BP && write_enable && wa == a)
        e_rd[k] = wd;
      else
        e_rd[k] = m_mem[a];
    end
    waw = issue_has_rd && issue_rd != 0
       && m_pend[issue_rd]
       && !(write_enable && wa == issue_rd);
    e_stall = issue_valid
           && (e_busy[0] || e_busy[1] || waw);
    n = 0;
    for (int i = 0; i < NR; i++)
      n += int'(m_pend[i]);
    e_cnt = n;
  endtask

  task automatic model_edge();
    if (write_enable && wa != 0) begin
      m_mem[wa]  = wd;
      m_pend[wa] = 1'b0;
    end
    if (issue_valid && !e_stall
        && issue_has_rd && issue_rd != 0)
      m_pend[issue_rd] = 1'b1;
  endtask

  // Compare against the model mid-cycle, then advance one edge.
  task automatic step(input string tag);
    model_eval();
    for (int k = 0; k < NRD; k++) begin
      check($sformatf("%s rd%0d", tag, k),
            rd[k*DW +: DW], e_rd[k]);
      check($sformatf("%s busy%0d", tag, k),
            rd_busy[k], e_busy[k]);
    end
    check({tag, " stall"}, stall, e_stall);
    check({tag, " cnt"}, pending_cnt, e_cnt);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tab[0]  = '{0, 0, 0, 0, 0, 1, 1, 3,
                0, 0, 2'b00, 0, 0};
    tab[1]  = '{0, 0, 0, 3, 0, 1, 0, 0,
                0, 0, 2'b01, 1, 1};
    tab[2]  = '{1, 3, 32'h12, 3, 0, 1, 0, 0,
                BP ? 32'h12 : 32'h0, 0, 2'b00, 0, 1};
    tab[3]  = '{0, 0, 0, 3, 0, 0, 0, 0,
                32'h12, 0, 2'b00, 0, 0};
    tab[4]  = '{1, 7, 32'hA5, 0, 7, 0, 0, 0,
                0, BP ? 32'hA5 : 32'h0, 2'b00, 0, 0};
    tab[5]  = '{0, 0, 0, 0, 7, 0, 0, 0,
                0, 32'hA5, 2'b00, 0, 0};
    tab[6]  = '{0, 0, 0, 0, 0, 1, 1, 9,
                0, 0, 2'b00, 0, 0};
    tab[7]  = '{1, 9, 32'h99, 0, 0, 1, 1, 9,
                0, 0, 2'b00, 0, 1};
    tab[8]  = '{0, 0, 0, 9, 0, 0, 0, 0,
                32'h99, 0, 2'b01, 0, 1};
    tab[9]  = '{0, 0, 0, 0, 9, 1, 0, 0,
                0, 32'h99, 2'b10, 1, 1};
    tab[10] = '{1, 0, 32'hFFFFFFFF, 0, 0, 1, 1, 0,
                0, 0, 2'b00, 0, 1};
    tab[11] = '{0, 0, 0, 0, 0, 0, 0, 0,
                0, 0, 2'b00, 0, 1};

    // Power-on reset.
    idle();
    rst = 1'b1;
    model_reset();
    #2;
    check("reset rd", rd, 0);
    check("reset busy", rd_busy, 0);
    check("reset stall", stall, 0);
    check("reset cnt", pending_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset mid-write: prime x5 and a pending x6 first.
    write_enable = 1'b1;
    wa = 5;
    wd = 32'h1111;
    #2 step("prime_w");
    idle();
    issue_valid  = 1'b1;
    issue_has_rd = 1'b1;
    issue_rd     = 6;
    #2 step("prime_i");
    idle();
    write_enable = 1'b1;
    wa = 5;
    wd = 32'hDEADBEEF;
    ra = {5'd6, 5'd5};
    #2;
    rst = 1'b1;
    #1;
    check("rstw rd0", rd[DW-1:0], 0);
    check("rstw busy", rd_busy, 0);
    check("rstw cnt", pending_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    idle();
    ra = {5'd6, 5'd5};
    #2;
    check("rstw after rd0", rd[DW-1:0], 0);
    check("rstw after cnt", pending_cnt, 0);
    step("rstw_m");

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      write_enable = tab[i].we;
      wa           = tab[i].wa;
      wd           = tab[i].wd;
      ra           = {tab[i].ra1, tab[i].ra0};
      issue_valid  = tab[i].iv;
      issue_has_rd = tab[i].hrd;
      issue_rd     = tab[i].ird;
      #2;
      check($sformatf("tab%0d rd0", i),
            rd[DW-1:0], tab[i].rd0);
      check($sformatf("tab%0d rd1", i),
            rd[2*DW-1:DW], tab[i].rd1);
      check($sformatf("tab%0d busy", i),
            rd_busy, tab[i].busy);
      check($sformatf("tab%0d stall", i),
            stall, tab[i].stall);
      check($sformatf("tab%0d cnt", i),
            pending_cnt, tab[i].cnt);
      step($sformatf("tab%0d", i));
    end

    // Retire x9, then fill every non-zero register.
    idle();
    write_enable = 1'b1;
    wa = 9;
    wd = 32'h9;
    #2 step("drain9");
    for (int r = 1; r < NR; r++) begin
      idle();
      issue_valid  = 1'b1;
      issue_has_rd = 1'b1;
      issue_rd     = AW'(r);
      #2 step($sformatf("fill%0d", r));
    end
    idle();
    #2;
    check("fill cnt", pending_cnt, NR - 1);
    issue_valid  = 1'b1;
    issue_has_rd = 1'b1;
    issue_rd     = 4;
    #2;
    check("fill waw stall", stall, 1);
    step("fill_waw");
    idle();
    #2;
    check("fill cnt hold", pending_cnt, NR - 1);

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      write_enable = ($urandom_range(0, 9) < 6);
      wa           = AW'($urandom);
      wd           = $urandom;
      ra           = (NRD*AW)'($urandom);
      issue_valid  = $urandom_range(0, 1) == 1;
      issue_has_rd = $urandom_range(0, 3) != 0;
      issue_rd     = AW'($urandom);
      #2 step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
